// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state type and error codes for the UART program loader
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } loader_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;

endpackage

// File: rtl/loader_word_packer.sv
// rtl/loader_word_packer.sv - packs a byte stream into words of WORD_BYTES bytes
module loader_word_packer #(
    parameter int WORD_BYTES = 4,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [7:0]              i_byte,
    input  logic                    i_strobe,
    input  logic                    i_clear,
    output logic [8*WORD_BYTES-1:0] o_word,
    output logic                    o_word_valid,
    output logic                    o_mid_word
);

    localparam int W     = 8 * WORD_BYTES;
    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    logic [W-1:0]     r_word;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     w_word;
    logic             w_last;

    // The completing byte is merged combinationally so the full word is usable in its strobe cycle.
    always_comb begin
        w_word = r_word;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (i_strobe && (r_idx == IDX_W'(k))) begin
                if (BIG_ENDIAN) begin
                    w_word[W-1-8*k -: 8] = i_byte;
                end else begin
                    w_word[8*k +: 8] = i_byte;
                end
            end
        end
    end

    assign w_last       = i_strobe && (r_idx == LAST_IDX);
    assign o_word       = w_word;
    assign o_word_valid = w_last;
    assign o_mid_word   = (r_idx != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_clear) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_strobe) begin
            r_word <= w_word;
            r_idx  <= w_last ? '0 : r_idx + 1'b1;
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - boot loader writing received words to instruction memory
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int WORD_BYTES  = 4,
    parameter int ADDR_W      = 10,
    parameter bit BIG_ENDIAN  = 1'b1,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    output logic                    o_mem_we,
    output logic [ADDR_W-1:0]       o_mem_addr,
    output logic [8*WORD_BYTES-1:0] o_mem_wdata,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [1:0]              o_err_code,
    output logic [ADDR_W:0]         o_entry_pc,
    output logic [ADDR_W:0]         o_word_count
);

    localparam int W = 8 * WORD_BYTES;
    localparam logic [W-1:0]    TERMINATOR = '1;
    localparam logic [ADDR_W:0] LAST_INDEX = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [31:0]     GAP_LIMIT  = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

    loader_state_t     r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [1:0]        r_err_code;
    logic [ADDR_W:0]   r_entry_pc;
    logic [ADDR_W:0]   r_word_count;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [W-1:0]      r_mem_wdata;
    logic [31:0]       r_gap;

    logic              w_strobe;
    logic              w_clear;
    logic [W-1:0]      w_word;
    logic              w_word_valid;
    logic              w_mid_word;
    logic              w_timeout;

    assign w_strobe  = (r_state == LOAD) && i_rx_valid;
    assign w_clear   = (r_state != LOAD);
    // A byte arriving in the limit cycle wins over the timeout.
    assign w_timeout = (TIMEOUT_CYC > 0) && (r_state == LOAD) && w_mid_word
                       && !i_rx_valid && (r_gap == GAP_LIMIT);

    loader_word_packer #(
        .WORD_BYTES (WORD_BYTES),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_byte       (i_rx_data),
        .i_strobe     (w_strobe),
        .i_clear      (w_clear),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_mid_word   (w_mid_word)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_entry_pc   <= '0;
            r_word_count <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_gap        <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (i_start) begin
                        r_state      <= LOAD;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_err_code   <= ERR_NONE;
                        r_entry_pc   <= '0;
                        r_word_count <= '0;
                        r_gap        <= '0;
                    end
                end
                LOAD: begin
                    if (w_strobe) begin
                        r_gap <= '0;
                    end else if (w_mid_word) begin
                        r_gap <= r_gap + 32'd1;
                    end
                    if (w_word_valid) begin
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= r_word_count[ADDR_W-1:0];
                        r_mem_wdata  <= w_word;
                        r_word_count <= r_word_count + 1'b1;
                        if (w_word == TERMINATOR) begin
                            r_entry_pc <= r_word_count + 1'b1;
                            r_state    <= DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else if (r_word_count == LAST_INDEX) begin
                            r_state    <= ERR;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                            r_err_code <= ERR_OVF;
                        end
                    end else if (w_timeout) begin
                        r_state    <= ERR;
                        r_busy     <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= ERR_TMO;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_err_code   = r_err_code;
    assign o_entry_pc   = r_entry_pc;
    assign o_word_count = r_word_count;

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Parametrised boot-time loader between the UART byte receiver and instruction memory. It packs a stream of received bytes into words of configurable width and byte order, writes each word through a single-port memory write interface, and stops on a terminator word. It then reports the entry PC, or an error on overflow or inter-byte timeout. The core holds in reset-like idle via `busy` until `done` rises.

## Interface
- `WORD_BYTES`, 4: bytes per word; word width `W = 8*WORD_BYTES`; legal values 1..8.
- `ADDR_W`, 10: memory address width; depth `2**ADDR_W` words.
- `BIG_ENDIAN`, 1: 1 means the first byte received lands in bits `[W-1:W-8]`; 0 means the first byte lands in `[7:0]`.
- `TIMEOUT_CYC`, 0: maximum number of `CLK` cycles allowed between bytes of one word; 0 disables the timeout.
- `CLK` in 1: single clock.
- `RST` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERR.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe marking `rx_data` valid.
- `mem_we` out 1: memory write enable, asserted for exactly one cycle per word.
- `mem_addr` out ADDR_W: word address to write.
- `mem_wdata` out W: assembled word.
- `busy` out 1: high while in LOAD.
- `done` out 1: level; high in DONE.
- `error` out 1: level; high in ERR.
- `err_code` out 2: 0 = none, 1 = overflow, 2 = timeout.
- `entry_pc` out ADDR_W+1: terminator index + 1; valid while `done` is high.
- `word_count` out ADDR_W+1: number of words written so far.

## Operation
- States: IDLE, LOAD, DONE, ERR.
  - IDLE → LOAD on `start`.
  - DONE → LOAD and ERR → LOAD on `start`. A restart clears the counters, `err_code` and `entry_pc`, and starts again at address 0.
- In LOAD, each `rx_valid` stores `rx_data` into byte slot `byte_idx`, counting 0..WORD_BYTES-1.
  - Slot position follows `BIG_ENDIAN`.
  - `byte_idx` wraps to 0 after the last slot.
- `rx_valid` outside LOAD is dropped. Bytes arriving in DONE or ERR are not written.
- On the last byte of a word:
  - write the word to `mem_addr = word_count[ADDR_W-1:0]`;
  - increment `word_count`.
- Terminator: a complete word equal to all-ones (`W` bits).
  - The terminator word is still written to memory.
  - `entry_pc` is set to the terminator's index + 1.
  - Next state is DONE.
- Overflow: a completed non-terminator word written at index `2**ADDR_W - 1`.
  - That word is still written.
  - Next state is ERR with `err_code` = 1.
- Timeout (when `TIMEOUT_CYC` > 0):
  - The gap counter runs only while `byte_idx` ≠ 0.
  - It is cleared on every accepted byte.
  - Reaching `TIMEOUT_CYC` leads to ERR with `err_code` = 2.
  - The partial word is discarded and never written.
- `rx_valid` and a timeout in the same cycle: the byte wins and the counter clears.
- `start` during LOAD is ignored.
- `RST` asserted mid-load:
  - all state returns immediately to IDLE;
  - the partial word is lost;
  - memory contents are not touched.
- Reset values: state IDLE, every output 0, `mem_wdata` 0.

## Timing
- `mem_we`, `mem_addr` and `mem_wdata` are registered. `mem_we` is high in the cycle after the `rx_valid` that carried the final byte.
- `done` or `error` rises in the same cycle as the final `mem_we`; `busy` falls in that cycle.
- `start` → `busy` high on the next cycle.
- Back-to-back `rx_valid` on consecutive cycles must be accepted without loss; throughput is 1 byte per cycle.
- `word_count` updates in the same cycle as `mem_we`.
- Timeout fires on the cycle where the gap count equals `TIMEOUT_CYC`. Example: with `TIMEOUT_CYC` = 5, a byte at cycle t and no further byte gives ERR visible at t+6.

## Structure
- Package `loader_pkg`:
  - state enum `loader_state_t` (IDLE, LOAD, DONE, ERR);
  - error-code localparams `ERR_NONE`, `ERR_OVF`, `ERR_TMO`.
- Sub-module `loader_word_packer`:
  - parametrised by `WORD_BYTES` and `BIG_ENDIAN`;
  - inputs: byte, strobe, clear;
  - outputs: word, word_valid pulse, mid_word flag.
- The top level holds the FSM, the address counter, the timeout counter and terminator compare.
- The top level connects to the existing `receiver` outside this block.

## Test plan
1. Default parameters; `start`; stream bytes 12 34 56 78, then FF FF FF FF.
   - Expect writes 0x12345678@0 and 0xFFFFFFFF@1.
   - Expect `done` high, `entry_pc` = 2, `word_count` = 2.
2. `BIG_ENDIAN` = 0, `WORD_BYTES` = 2; bytes 34 12, FF FF.
   - Expect 0x1234@0, `entry_pc` = 2.
3. `ADDR_W` = 2; send 4 non-terminator words.
   - Expect 4 writes at addresses 0..3, then `error` = 1 with `err_code` = 1.
   - A fifth word is ignored.
4. `TIMEOUT_CYC` = 5; send 2 bytes, then idle 10 cycles.
   - Expect ERR with `err_code` = 2 and no `mem_we`.
   - `start` then restarts at address 0.
5. Assert `RST` after 6 bytes.
   - Expect all outputs 0 and IDLE.
   - A fresh load writes from address 0 with byte slots aligned.
6. `rx_valid` held high for 8 consecutive cycles with 8 bytes.
   - Expect exactly 2 `mem_we` pulses and no dropped byte.
